// File: rtl/sdram_bist_pkg.sv
// Shared types for the SDRAM BIST engine: FSM states, pattern modes and error-counter sizing.
package sdram_bist_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned ERR_W  = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    typedef enum logic [MODE_W-1:0] {
        MODE_ADDR  = 2'd0,
        MODE_NADDR = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

endpackage

// File: rtl/sdram_bist_pattern.sv
// Test-pattern generator: returns the word for the current address, and steps a Galois LFSR on advance.
// On restart the LFSR is reloaded from seed; the output reflects the reloaded value in the same cycle.
module sdram_bist_pattern
    import sdram_bist_pkg::*;
#(
    parameter int unsigned    DW        = 16,
    parameter logic [DW-1:0]  LFSR_TAPS = DW'(16'hB400)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart_i,
    input  logic          advance_i,
    input  mode_e         mode_i,
    input  logic [DW-1:0] seed_i,
    input  logic [DW-1:0] addr_i,
    output logic [DW-1:0] data_c_o
);

    logic [DW-1:0] lfsr_q, lfsr_d;
    logic [DW-1:0] seed_fix_c;
    logic [DW-1:0] lfsr_cur_c;

    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed becomes 1.
    always_comb begin
        seed_fix_c = (seed_i == '0) ? DW'(1) : seed_i;
        lfsr_cur_c = restart_i ? seed_fix_c : lfsr_q;
        lfsr_d     = lfsr_q;
        if (advance_i) begin
            lfsr_d = lfsr_step(lfsr_cur_c);
        end else if (restart_i) begin
            lfsr_d = seed_fix_c;
        end
        data_c_o = seed_i;
        case (mode_i)
            MODE_ADDR:  data_c_o = addr_i;
            MODE_NADDR: data_c_o = ~addr_i;
            MODE_LFSR:  data_c_o = lfsr_cur_c;
            default:    data_c_o = seed_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/sdram_bist.sv
// SDRAM BIST engine: writes a generated pattern over a word range, reads it back and checks
// each in-order response against a second, independently stepped copy of the generator.
module sdram_bist
    import sdram_bist_pkg::*;
#(
    parameter int unsigned   AW              = 23,
    parameter int unsigned   DW              = 16,
    parameter int unsigned   MAX_OUTSTANDING = 4,
    parameter logic [DW-1:0] LFSR_TAPS       = DW'(16'hB400)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      length,
    input  logic [1:0]       mode,
    input  logic [DW-1:0]    seed,
    output logic             req_valid,
    output logic             req_write,
    output logic [AW-1:0]    req_addr,
    output logic [DW-1:0]    req_wdata,
    input  logic             req_ready,
    input  logic             rsp_valid,
    input  logic [DW-1:0]    rsp_rdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [AW-1:0]    first_err_addr,
    output logic [DW-1:0]    first_err_data
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [DW-1:0]     seed_q, seed_d;
    logic [AW-1:0]     base_q, base_d;
    logic [CW-1:0]     len_q, len_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OW-1:0]     out_q, out_d;
    logic [AW-1:0]     exp_addr_q, exp_addr_d;
    logic              req_valid_q, req_valid_d;
    logic              req_write_q, req_write_d;
    logic [AW-1:0]     req_addr_q, req_addr_d;
    logic [DW-1:0]     req_wdata_q, req_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [AW-1:0]     fea_q, fea_d;
    logic [DW-1:0]     fed_q, fed_d;

    logic              hs_c, rd_hs_c, rsp_ok_c, start_ok_c;
    logic              wr_restart_c, wr_advance_c;
    logic [DW-1:0]     wr_addr_c, wr_data_c, exp_data_c;
    mode_e             pat_mode_c;
    logic [DW-1:0]     pat_seed_c;

    assign hs_c       = req_valid_q & req_ready;
    assign rd_hs_c    = hs_c & (state_q == ST_READ);
    assign rsp_ok_c   = rsp_valid & (out_q != '0);
    assign start_ok_c = start & (state_q == ST_IDLE);
    assign wr_addr_c  = DW'((state_q == ST_IDLE) ? base_addr : req_addr_q + AW'(1));

    // Generators see the live inputs on the start cycle, the latched copies afterwards.
    assign pat_mode_c = (state_q == ST_IDLE) ? mode_e'(mode) : mode_q;
    assign pat_seed_c = (state_q == ST_IDLE) ? seed : seed_q;

    sdram_bist_pattern #(.DW(DW), .LFSR_TAPS(LFSR_TAPS)) u_wr_pat (
        .clk       (clk),
        .rst       (rst),
        .restart_i (wr_restart_c),
        .advance_i (wr_advance_c),
        .mode_i    (pat_mode_c),
        .seed_i    (pat_seed_c),
        .addr_i    (wr_addr_c),
        .data_c_o  (wr_data_c)
    );

    sdram_bist_pattern #(.DW(DW), .LFSR_TAPS(LFSR_TAPS)) u_exp_pat (
        .clk       (clk),
        .rst       (rst),
        .restart_i (start_ok_c),
        .advance_i (rsp_ok_c),
        .mode_i    (pat_mode_c),
        .seed_i    (pat_seed_c),
        .addr_i    (DW'(exp_addr_q)),
        .data_c_o  (exp_data_c)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        base_d       = base_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        exp_addr_d   = exp_addr_q;
        req_valid_d  = req_valid_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_d        = err_q;
        fea_d        = fea_q;
        fed_d        = fed_q;
        wr_restart_c = 1'b0;
        wr_advance_c = 1'b0;

        if (rd_hs_c && !rsp_ok_c) begin
            out_d = out_q + OW'(1);
        end else if (!rd_hs_c && rsp_ok_c) begin
            out_d = out_q - OW'(1);
        end

        // Response checker; a zero error count marks the first mismatch of the run.
        if (rsp_ok_c) begin
            exp_addr_d = exp_addr_q + AW'(1);
            if (rsp_rdata != exp_data_c) begin
                if (err_q != ERR_MAX) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (err_q == '0) begin
                    fea_d = exp_addr_q;
                    fed_d = rsp_rdata;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d     = mode_e'(mode);
                    seed_d     = seed;
                    base_d     = base_addr;
                    len_d      = length;
                    exp_addr_d = base_addr;
                    err_d      = '0;
                    fea_d      = '0;
                    fed_d      = '0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    if (length == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d      = ST_WRITE;
                        cnt_d        = length;
                        wr_restart_c = 1'b1;
                        wr_advance_c = 1'b1;
                        req_valid_d  = 1'b1;
                        req_write_d  = 1'b1;
                        req_addr_d   = base_addr;
                        req_wdata_d  = wr_data_c;
                    end
                end
            end
            ST_WRITE: begin
                if (hs_c) begin
                    if (cnt_q == CW'(1)) begin
                        state_d     = ST_READ;
                        cnt_d       = len_q;
                        req_write_d = 1'b0;
                        req_addr_d  = base_q;
                    end else begin
                        cnt_d        = cnt_q - CW'(1);
                        wr_advance_c = 1'b1;
                        req_addr_d   = req_addr_q + AW'(1);
                        req_wdata_d  = wr_data_c;
                    end
                end
            end
            ST_READ: begin
                if (hs_c) begin
                    cnt_d      = cnt_q - CW'(1);
                    req_addr_d = req_addr_q + AW'(1);
                end
                req_valid_d = (cnt_d != '0) && (out_d < OUT_MAX);
                if (cnt_d == '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_q == '0) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_q == '0);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ADDR;
            seed_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            exp_addr_q  <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fea_q       <= '0;
            fed_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            base_q      <= base_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            exp_addr_q  <= exp_addr_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fea_q       <= fea_d;
            fed_q       <= fed_d;
        end
    end

    assign req_valid      = req_valid_q;
    assign req_write      = req_write_q;
    assign req_addr       = req_addr_q;
    assign req_wdata      = req_wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = fea_q;
    assign first_err_data = fed_q;

endmodule

// File: tb/tb_sdram_bist.sv
// Bench for sdram_bist: behavioural SDRAM controller with stalls/latency, scoreboarded writes and results.
module tb_sdram_bist;

    localparam int unsigned AW = 23;
    localparam int unsigned DW = 16;

    logic          clk, rst, start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [1:0]    mode;
    logic [DW-1:0] seed;
    logic          req_valid, req_write, req_ready, rsp_valid;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, rsp_rdata;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;

    sdram_bist dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .mode(mode), .seed(seed), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct packed { logic [AW-1:0] addr; logic [31:0] due; } rd_t;
    typedef struct packed { logic ok; logic [15:0] err; logic [AW-1:0] fa; logic [DW-1:0] fd; } res_t;

    wr_t exp_wr[$];
    rd_t rd_q[$];
    res_t res_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;
    int outst = 0;
    int unsigned ready_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    bit corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    logic prev_valid = 1'b0;
    logic prev_hs = 1'b0;
    logic prev_write = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] x);
        logic [DW-1:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    // Controller model: decides ready/response for the coming edge and logs the handshake it will see.
    always @(negedge clk) begin : ctrl_model
        rd_t r;
        wr_t w;
        logic hs;
        cyc++;
        if (rst) begin
            outst = 0;
        end else if (prev_valid && !prev_hs) begin
            chk("stall_valid_held", 32'(req_valid), 32'd1);
            chk("stall_write_held", 32'(req_write), 32'(prev_write));
            chk("stall_addr_held", 32'(req_addr), 32'(prev_addr));
            chk("stall_wdata_held", 32'(req_wdata), 32'(prev_wdata));
        end
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
            r = rd_q.pop_front();
            rsp_valid = 1'b1;
            if (corrupt_en && r.addr == corrupt_addr) rsp_rdata = 16'hDEAD;
            else if (mem.exists(r.addr)) rsp_rdata = mem[r.addr];
            if (outst > 0) outst--;
        end
        req_ready = ($urandom_range(99) < ready_pct);
        hs = req_valid && req_ready && !rst;
        if (hs && req_write) begin
            mem[req_addr] = req_wdata;
            chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                chk("wr_addr", 32'(req_addr), 32'(w.addr));
                chk("wr_data", 32'(req_wdata), 32'(w.data));
            end
        end else if (hs) begin
            r.addr = req_addr;
            r.due  = cyc + $urandom_range(lat_max, lat_min);
            rd_q.push_back(r);
            outst++;
            chk("outstanding_le_4", 32'(outst <= 4), 32'd1);
        end
        prev_valid = req_valid && !rst;
        prev_hs    = hs;
        prev_write = req_write;
        prev_addr  = req_addr;
        prev_wdata = req_wdata;
    end

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req_valid"}, 32'(req_valid), 32'd0);
        chk({pfx, "_req_write"}, 32'(req_write), 32'd0);
        chk({pfx, "_req_addr"}, 32'(req_addr), 32'd0);
        chk({pfx, "_req_wdata"}, 32'(req_wdata), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_pass"}, 32'(pass), 32'd0);
        chk({pfx, "_err_count"}, 32'(err_count), 32'd0);
        chk({pfx, "_first_err_addr"}, 32'(first_err_addr), 32'd0);
        chk({pfx, "_first_err_data"}, 32'(first_err_data), 32'd0);
    endtask

    task automatic push_res(input logic ok, input logic [15:0] err, input logic [AW-1:0] fa, input logic [DW-1:0] fd);
        res_t r;
        r.ok = ok; r.err = err; r.fa = fa; r.fd = fd;
        res_q.push_back(r);
    endtask

    // Queue the expected write stream, pulse start, then scramble the inputs.
    task automatic start_run(input logic [AW-1:0] b, input logic [AW:0] l, input logic [1:0] m, input logic [DW-1:0] s);
        wr_t w;
        logic [DW-1:0] lf;
        lf = (s == '0) ? 16'h0001 : s;
        for (int i = 0; i < int'(l); i++) begin
            w.addr = b + AW'(i);
            case (m)
                2'd0: w.data = w.addr[DW-1:0];
                2'd1: w.data = ~w.addr[DW-1:0];
                2'd2: begin w.data = lf; lf = lfsr_next(lf); end
                default: w.data = s;
            endcase
            exp_wr.push_back(w);
        end
        @(negedge clk); #1;
        start = 1'b1; base_addr = b; length = l; mode = m; seed = s;
        @(posedge clk); #1;
        start = 1'b0; base_addr = ~b; length = 24'd3; mode = m + 2'd1; seed = ~s;
        @(negedge clk); #1;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("first_req_valid", 32'(req_valid), 32'd1);
        chk("first_req_write", 32'(req_write), 32'd1);
        chk("first_req_addr", 32'(req_addr), 32'(b));
    endtask

    task automatic wait_done(input int budget);
        res_t r;
        bit got;
        got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk); #1;
            if (done) begin got = 1'b1; break; end
        end
        chk("done_seen", 32'(got), 32'd1);
        if (res_q.size() != 0) begin
            r = res_q.pop_front();
            if (got) begin
                chk("pass", 32'(pass), 32'(r.ok));
                chk("err_count", 32'(err_count), 32'(r.err));
                chk("first_err_addr", 32'(first_err_addr), 32'(r.fa));
                chk("first_err_data", 32'(first_err_data), 32'(r.fd));
                chk("busy_at_done", 32'(busy), 32'd0);
                @(negedge clk); #1;
                chk("done_one_cycle", 32'(done), 32'd0);
            end
        end
        chk("writes_consumed", 32'(exp_wr.size()), 32'd0);
        chk("reads_answered", 32'(rd_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; mode = '0; seed = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        // Incrementing address pattern through an ideal controller.
        push_res(1'b1, 16'd0, '0, '0);
        start_run(23'h000010, 24'd8, 2'd0, 16'h0000);
        wait_done(200);

        // Same run with one corrupted read word.
        corrupt_en = 1'b1; corrupt_addr = 23'h000013;
        push_res(1'b0, 16'd1, 23'h000013, 16'hDEAD);
        start_run(23'h000010, 24'd8, 2'd0, 16'h0000);
        wait_done(200);
        corrupt_en = 1'b0;

        // Zero length: no requests, done two cycles after start.
        @(negedge clk); #1;
        start = 1'b1; length = '0; base_addr = 23'h000055;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        chk("len0_busy", 32'(busy), 32'd1);
        chk("len0_done_early", 32'(done), 32'd0);
        chk("len0_pass_cleared", 32'(pass), 32'd0);
        chk("len0_err_cleared", 32'(err_count), 32'd0);
        chk("len0_no_req_a", 32'(req_valid), 32'd0);
        @(negedge clk); #1;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_pass", 32'(pass), 32'd1);
        chk("len0_no_req_b", 32'(req_valid), 32'd0);

        // Inverted address wrapping past the top of the address space.
        push_res(1'b1, 16'd0, '0, '0);
        start_run(23'h7FFFFE, 24'd4, 2'd1, 16'h0000);
        wait_done(200);

        // LFSR with zero seed, random stalls and latency; a second start mid-run must be ignored.
        ready_pct = 60; lat_min = 1; lat_max = 6;
        push_res(1'b1, 16'd0, '0, '0);
        start_run(23'h001000, 24'd40, 2'd2, 16'h0000);
        repeat (10) @(negedge clk);
        #1; start = 1'b1; length = '0; base_addr = '0; mode = 2'd3;
        @(posedge clk); #1; start = 1'b0;
        chk("start_while_busy_ignored", 32'(busy), 32'd1);
        wait_done(3000);

        // Constant pattern with a corrupted word and stalls.
        ready_pct = 70; lat_min = 2; lat_max = 4;
        corrupt_en = 1'b1; corrupt_addr = 23'h000202;
        push_res(1'b0, 16'd1, 23'h000202, 16'hDEAD);
        start_run(23'h000200, 24'd6, 2'd3, 16'hA5C3);
        wait_done(1000);
        corrupt_en = 1'b0;

        // Reset while three reads are in flight.
        ready_pct = 100; lat_min = 6; lat_max = 6;
        start_run(23'h000100, 24'd16, 2'd2, 16'h1234);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk); #1;
            if (outst == 3 && req_valid && !req_write) break;
        end
        chk("three_outstanding_reached", 32'(outst), 32'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midrun_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (rd_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("stale_rsp_no_err", 32'(err_count), 32'd0);
        chk("stale_rsp_idle_busy", 32'(busy), 32'd0);
        chk("stale_rsp_no_req", 32'(req_valid), 32'd0);
        chk("reset_run_writes_done", 32'(exp_wr.size()), 32'd0);

        // Fresh run after reset.
        ready_pct = 80; lat_min = 1; lat_max = 3;
        push_res(1'b1, 16'd0, '0, '0);
        start_run(23'h000300, 24'd12, 2'd2, 16'h1234);
        wait_done(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
